ascon_permutation_sequencer: RTL
================================

ASCON_PERMUTATION_SEQUENCER -- requirements
Module: ascon_permutation_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 UNROLL, 1, rounds computed per clock; legal values are 1, 2 and 4.
REQ-003 clk_i  input  1  rising-edge clock.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 in_valid_i  input  1  request to start a permutation.
REQ-006 in_ready_o  output  1  the block can accept a request.
REQ-007 state_i  input  ascon_state_t  permutation input state.
REQ-008 rnd_i  input  5  round count; legal values are 1..16.
REQ-009 out_valid_o  output  1  state_o holds the finished result.
REQ-010 out_ready_i  input  1  the consumer accepts the result.
REQ-011 state_o  output  ascon_state_t  permutation result.
REQ-012 busy_o  output  1  high in RUN and DONE.
REQ-013 err_o  output  1  one-cycle pulse when a request is rejected.

Function
REQ-014 FSM states: IDLE, RUN, DONE.
REQ-015 in_ready_o SHALL be 1 only in IDLE.
REQ-016 Accept: in_valid_i and in_ready_o both high at a clock edge.
REQ-017 On accept, the block SHALL register state_i and rnd_i, load the round index i = 16 - rnd_i, and go to RUN.
REQ-018 Reject: on an accept edge where rnd_i is 0, rnd_i > 16, or rnd_i is not a multiple of UNROLL, the block SHALL pulse err_o for one cycle and stay in IDLE.
REQ-019 RUN: each cycle SHALL apply UNROLL rounds to the state register and advance i by UNROLL.
REQ-020 Each round SHALL be, in order:
  - constant addition: XOR c_i into bits 7:0 of word 2; c_i = 3c,2d,1e,0f,f0,e1,d2,c3,b4,a5,96,87,78,69,5a,4b for i = 0..15;
  - bit-sliced S-box, column {x0..x4} with x0 as MSB;
  - linear layer: word0 (19,28), word1 (61,39), word2 (1,6), word3 (10,17), word4 (7,41); word ^= ror(word,a) ^ ror(word,b).
REQ-021 RUN SHALL exit to DONE on the edge that finishes round i = 15.
REQ-022 Latency SHALL be exactly rnd_i/UNROLL cycles from the accept edge to out_valid_o high.
REQ-023 DONE: out_valid_o = 1 and state_o = result, both held stable until out_ready_i = 1.
REQ-024 A handshake in DONE SHALL return the block to IDLE.
REQ-025 in_ready_o SHALL rise in the cycle after the output handshake (no same-cycle turnaround), giving a minimum issue interval of rnd_i/UNROLL + 1 cycles.
REQ-026 Outside DONE, state_o SHALL show the internal state register and out_valid_o SHALL be 0.
REQ-027 Input changes while not in IDLE SHALL be ignored.
REQ-028 Round index arithmetic SHALL be 5-bit unsigned and SHALL never wrap past 15.

Reset
REQ-029 Asserting rst_ni SHALL force IDLE with the state register = 0 and the round index = 0.
REQ-030 Reset values: in_ready_o = 1, out_valid_o = 0, busy_o = 0, err_o = 0, state_o = 0.
REQ-031 Reset asserted in RUN or DONE SHALL abandon the operation; no out_valid_o SHALL follow.
REQ-032 After rst_ni is released, the first clock edge SHALL be able to accept a request.

Structure
REQ-033 ascon_pkg SHALL hold: ascon_state_t, NUM_WORDS = 5, WORD_WIDTH = 64, the round-constant table, and the FSM state enum.
REQ-034 One combinational sub-module, ascon_round, SHALL implement a single round: constant addition, the existing substitution layer, then the linear layer.
REQ-035 ascon_round SHALL take the round index as an input and SHALL be instantiated UNROLL times in a chain.
REQ-036 The sequencer SHALL hold the FSM, the round counter and the state register only.

Verification
REQ-037 UNROLL=1, zero state, rnd_i=1 -> out_valid_o after 1 cycle; word3 = 0x12E5_8000_0000_004B; word4 = 0.
REQ-038 UNROLL=1, zero state, rnd_i=12 -> out_valid_o after exactly 12 cycles; state_o matches the golden model and the SP 800-232 Ascon-p[12] KAT.
REQ-039 rnd_i=8 with UNROLL=1, 2 and 4 -> identical state_o; latency 8, 4 and 2 cycles respectively.
REQ-040 rnd_i=0, rnd_i=17, and (UNROLL=4, rnd_i=6) -> err_o pulses for 1 cycle; in_ready_o stays 1; no out_valid_o.
REQ-041 Hold out_ready_i=0 for 5 cycles in DONE while toggling state_i and in_valid_i -> state_o stable, no new accept; in_ready_o = 1 in the cycle after the handshake.
REQ-042 Assert rst_ni low mid-RUN (after round 3 of p[12]) -> all outputs at reset values immediately; a fresh request completes correctly.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon permutation sequencer:
// state layout, round-constant table, FSM encoding and rotate helper.
package ascon_pkg;

  localparam int unsigned NUM_WORDS  = 5;
  localparam int unsigned WORD_WIDTH = 64;

  // Word 0 sits in the least-significant 64 bits.
  typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fsm_state_e;

  // Entry i is c_i; a p[n] permutation starts at i = 16 - n.
  localparam logic [15:0][7:0] ROUND_CONST = {
    8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96, 8'ha5, 8'hb4,
    8'hc3, 8'hd2, 8'he1, 8'hf0, 8'h0f, 8'h1e, 8'h2d, 8'h3c
  };

  function automatic logic [WORD_WIDTH-1:0] ror64(input logic [WORD_WIDTH-1:0] x,
                                                  input int unsigned n);
    return (x >> n) | (x << (WORD_WIDTH - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bit-sliced S-box,
// then the per-word linear diffusion layer.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  input  logic [3:0]   idx_i,
  output ascon_state_t state_o
);

  logic [7:0]            w_c;
  logic [WORD_WIDTH-1:0] w_x0, w_x1, w_x2, w_x3, w_x4;
  logic [WORD_WIDTH-1:0] w_t0, w_t1, w_t2, w_t3, w_t4;
  logic [WORD_WIDTH-1:0] w_y0, w_y1, w_y2, w_y3, w_y4;
  logic [WORD_WIDTH-1:0] w_s0, w_s1, w_s2, w_s3, w_s4;

  assign w_c = ROUND_CONST[idx_i];

  // Constant addition folded into the S-box input mixing of word 2.
  assign w_x0 = state_i[0] ^ state_i[4];
  assign w_x1 = state_i[1];
  assign w_x2 = state_i[2] ^ {{(WORD_WIDTH-8){1'b0}}, w_c} ^ state_i[1];
  assign w_x3 = state_i[3];
  assign w_x4 = state_i[4] ^ state_i[3];

  assign w_t0 = ~w_x0 & w_x1;
  assign w_t1 = ~w_x1 & w_x2;
  assign w_t2 = ~w_x2 & w_x3;
  assign w_t3 = ~w_x3 & w_x4;
  assign w_t4 = ~w_x4 & w_x0;

  assign w_y0 = w_x0 ^ w_t1;
  assign w_y1 = w_x1 ^ w_t2;
  assign w_y2 = w_x2 ^ w_t3;
  assign w_y3 = w_x3 ^ w_t4;
  assign w_y4 = w_x4 ^ w_t0;

  assign w_s0 = w_y0 ^ w_y4;
  assign w_s1 = w_y1 ^ w_y0;
  assign w_s2 = ~w_y2;
  assign w_s3 = w_y3 ^ w_y2;
  assign w_s4 = w_y4;

  assign state_o[0] = w_s0 ^ ror64(w_s0, 19) ^ ror64(w_s0, 28);
  assign state_o[1] = w_s1 ^ ror64(w_s1, 61) ^ ror64(w_s1, 39);
  assign state_o[2] = w_s2 ^ ror64(w_s2, 1)  ^ ror64(w_s2, 6);
  assign state_o[3] = w_s3 ^ ror64(w_s3, 10) ^ ror64(w_s3, 17);
  assign state_o[4] = w_s4 ^ ror64(w_s4, 7)  ^ ror64(w_s4, 41);

endmodule

// File: rtl/ascon_permutation_sequencer.sv
// Iterative Ascon-p[n] sequencer: UNROLL chained rounds per clock over a
// single state register, with a valid/ready request and result handshake.
module ascon_permutation_sequencer
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  ascon_state_t state_i,
  input  logic [4:0]   rnd_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output ascon_state_t state_o,
  output logic         busy_o,
  output logic         err_o
);

  fsm_state_e   r_fsm;
  ascon_state_t r_state;
  logic [4:0]   r_idx;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;
  logic         r_err;

  ascon_state_t w_chain [UNROLL+1];
  logic [4:0]   w_idx_next;
  logic         w_reject;

  assign w_chain[0] = r_state;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    logic [3:0] w_idx;
    assign w_idx = r_idx[3:0] + 4'(g);
    ascon_round u_round (
      .state_i (w_chain[g]),
      .idx_i   (w_idx),
      .state_o (w_chain[g+1])
    );
  end

  // Reaching 16 means the last chained round was i = 15; never stored.
  assign w_idx_next = r_idx + 5'(UNROLL);
  assign w_reject   = (rnd_i == 5'd0) || (rnd_i > 5'd16) ||
                      ((rnd_i & 5'(UNROLL - 1)) != 5'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm       <= StIdle;
      r_state     <= '0;
      r_idx       <= 5'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_fsm)
        StIdle: begin
          if (in_valid_i) begin
            if (w_reject) begin
              r_err <= 1'b1;
            end else begin
              r_state    <= state_i;
              r_idx      <= 5'd16 - rnd_i;
              r_fsm      <= StRun;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        StRun: begin
          r_state <= w_chain[UNROLL];
          if (w_idx_next == 5'd16) begin
            r_fsm       <= StDone;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= w_idx_next;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            r_fsm       <= StIdle;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_fsm <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign busy_o      = r_busy;
  assign err_o       = r_err;
  assign state_o     = r_state;

endmodule
